// File: rtl/pipelined_addsub_if.sv
// Handshake and operand/result bundle for the pipelined adder-subtractor.
// The master drives operands and out_ready; the slave returns results and in_ready.
interface pipelined_addsub_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             sub;
   logic             sat;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             c;
   logic             v;
   logic             z;

   modport master (
      output in_valid, a, b, ci, sub, sat, out_ready,
      input  in_ready, out_valid, y, c, v, z
   );

   modport slave (
      input  in_valid, a, b, ci, sub, sat, out_ready,
      output in_ready, out_valid, y, c, v, z
   );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract with a segmented carry chain, signed saturation and
// zero flag; one global advance stalls every stage together.
module pipelined_addsub #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 2
) (
   input logic              clk,
   input logic              rst_n,
   pipelined_addsub_if.slave bus
);
   localparam int unsigned SEG = WIDTH / STAGES;
   localparam int unsigned L   = STAGES - 1;

   // Bank k feeds stage k: bank 0 captures the input, stage k resolves segment k.
   logic [WIDTH-1:0] st_a   [STAGES];
   logic [WIDTH-1:0] st_b   [STAGES];
   logic [WIDTH-1:0] st_s   [STAGES];
   logic             st_c   [STAGES];
   logic             st_sat [STAGES];
   logic             st_vld [STAGES];

   logic [WIDTH-1:0] nx_s [STAGES];
   logic             nx_c [STAGES];

   logic             started;
   logic             adv;
   logic [WIDTH-1:0] raw;
   logic [WIDTH-1:0] ysat;
   logic             vraw;

   logic [WIDTH-1:0] y_q;
   logic             c_q;
   logic             v_q;
   logic             z_q;
   logic             ov_q;

   assign adv          = !ov_q || bus.out_ready;
   assign bus.in_ready = started && adv;
   assign bus.out_valid = ov_q;
   assign bus.y        = y_q;
   assign bus.c        = c_q;
   assign bus.v        = v_q;
   assign bus.z        = z_q;

   always_comb begin
      for (int unsigned k = 0; k < STAGES; k++) begin
         nx_s[k] = st_s[k];
         {nx_c[k], nx_s[k][k*SEG +: SEG]} = {1'b0, st_a[k][k*SEG +: SEG]}
                                          + {1'b0, st_b[k][k*SEG +: SEG]}
                                          + {{SEG{1'b0}}, st_c[k]};
      end
   end

   // Overflow and clamping look at the raw sum; zero flag sees the clamped value.
   always_comb begin
      raw  = nx_s[L];
      vraw = (st_a[L][WIDTH-1] == st_b[L][WIDTH-1]) && (raw[WIDTH-1] != st_a[L][WIDTH-1]);
      ysat = raw;
      if (st_sat[L] && vraw)
         ysat = {st_a[L][WIDTH-1], {(WIDTH-1){!st_a[L][WIDTH-1]}}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         started <= 1'b0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            st_a[k]   <= '0;
            st_b[k]   <= '0;
            st_s[k]   <= '0;
            st_c[k]   <= 1'b0;
            st_sat[k] <= 1'b0;
            st_vld[k] <= 1'b0;
         end
         y_q  <= '0;
         c_q  <= 1'b0;
         v_q  <= 1'b0;
         z_q  <= 1'b0;
         ov_q <= 1'b0;
      end else begin
         started <= 1'b1;
         if (adv) begin
            st_a[0]   <= bus.a;
            st_b[0]   <= bus.sub ? ~bus.b : bus.b;
            st_s[0]   <= '0;
            st_c[0]   <= bus.ci;
            st_sat[0] <= bus.sat;
            st_vld[0] <= bus.in_valid && bus.in_ready;
            for (int unsigned k = 1; k < STAGES; k++) begin
               st_a[k]   <= st_a[k-1];
               st_b[k]   <= st_b[k-1];
               st_s[k]   <= nx_s[k-1];
               st_c[k]   <= nx_c[k-1];
               st_sat[k] <= st_sat[k-1];
               st_vld[k] <= st_vld[k-1];
            end
            y_q  <= ysat;
            c_q  <= nx_c[L];
            v_q  <= vraw;
            z_q  <= (ysat == '0);
            ov_q <= st_vld[L];
         end
      end
   end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=16, STAGES=2) using an
// integer-arithmetic reference model and a result queue.
module tb_pipelined_addsub;
   localparam int unsigned W = 16;
   localparam int unsigned S = 2;

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   pipelined_addsub_if #(.WIDTH(W)) bus ();

   pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        ci;
      logic        sub;
      logic        sat;
      logic [15:0] y;
      logic        c;
      logic        v;
      logic        z;
   } vec_t;

   // Returns {y, c, v, z}.
   function automatic logic [18:0] model(input logic [15:0] a_, input logic [15:0] b_,
                                         input logic ci_, input logic sub_, input logic sat_);
      logic [15:0] be;
      logic [15:0] yy;
      int          full;
      int          ss;
      logic        cc;
      logic        vv;
      be   = sub_ ? ~b_ : b_;
      full = int'(a_) + int'(be) + int'(ci_);
      cc   = full > 65535;
      yy   = full[15:0];
      ss   = int'($signed(a_)) + int'($signed(be)) + int'(ci_);
      vv   = (ss > 32767) || (ss < -32768);
      if (sat_ && vv) yy = (ss > 0) ? 16'h7FFF : 16'h8000;
      return {yy, cc, vv, (yy == 16'h0000)};
   endfunction

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 7))
         0: return 16'h0000;
         1: return 16'h7FFF;
         2: return 16'h8000;
         3: return 16'hFFFF;
         4: return 16'h00FF;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic set_idle();
      bus.in_valid = 1'b0;
      bus.a = '0; bus.b = '0;
      bus.ci = 1'b0; bus.sub = 1'b0; bus.sat = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_idle();
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++;
      if ({bus.out_valid, bus.y, bus.c, bus.v, bus.z} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: ov=%b y=%h c=%b v=%b z=%b, required all zero",
                  bus.out_valid, bus.y, bus.c, bus.v, bus.z);
      end
      tests++;
      if (bus.in_ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_in_ready: got %b, required 0", bus.in_ready);
      end
      rst_n = 1'b1;
      #1;
      tests++;
      if (bus.in_ready !== 1'b0) begin
         fails++;
         $display("FAIL release_in_ready_early: got %b, required 0", bus.in_ready);
      end
      @(posedge clk); #1;
      tests++;
      if (bus.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL release_in_ready: got %b, required 1", bus.in_ready);
      end
   endtask

   task automatic test_vectors();
      vec_t vt [10];
      vt = '{
         '{16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0},
         '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
         '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0},
         '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0},
         '{16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0},
         '{16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0},
         '{16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0},
         '{16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFD, 1'b0, 1'b0, 1'b0},
         '{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0},
         '{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1}
      };
      bus.out_ready = 1'b1;
      foreach (vt[i]) begin
         @(posedge clk); #1;
         bus.in_valid = 1'b1;
         bus.a = vt[i].a; bus.b = vt[i].b;
         bus.ci = vt[i].ci; bus.sub = vt[i].sub; bus.sat = vt[i].sat;
         @(negedge clk);
         tests++;
         if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL vec%0d_in_ready: got %b, required 1", i, bus.in_ready);
         end
         @(posedge clk); #1;
         set_idle();
         @(posedge clk); #1;
         tests++;
         if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL vec%0d_early: out_valid %b one edge early, required 0", i, bus.out_valid);
         end
         @(posedge clk); #1;
         tests++;
         if ({bus.out_valid, bus.y, bus.c, bus.v, bus.z} !== {1'b1, vt[i].y, vt[i].c, vt[i].v, vt[i].z}) begin
            fails++;
            $display("FAIL vec%0d_result: ov=%b y=%h c=%b v=%b z=%b, required ov=1 y=%h c=%b v=%b z=%b",
                     i, bus.out_valid, bus.y, bus.c, bus.v, bus.z, vt[i].y, vt[i].c, vt[i].v, vt[i].z);
         end
      end
   endtask

   task automatic test_backpressure();
      int          issued = 0;
      int          got = 0;
      int          cyc = 0;
      logic [15:0] exp;
      while (got < 4 && cyc < 40) begin
         @(posedge clk); #1;
         bus.out_ready = !(cyc >= 3 && cyc <= 8);
         bus.in_valid  = issued < 4;
         bus.a = 16'(issued + 16); bus.b = 16'(issued);
         bus.ci = 1'b0; bus.sub = 1'b0; bus.sat = 1'b0;
         @(negedge clk);
         if (bus.out_valid && !bus.out_ready) begin
            tests++;
            if (bus.y !== 16'h0010 || bus.in_ready !== 1'b0) begin
               fails++;
               $display("FAIL bp_stall cyc%0d: y=%h in_ready=%b, required y=0010 in_ready=0",
                        cyc, bus.y, bus.in_ready);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            exp = 16'(16 + 2 * got);
            tests++;
            if (bus.y !== exp) begin
               fails++;
               $display("FAIL bp_order #%0d: y=%h, required %h", got, bus.y, exp);
            end
            got++;
         end
         if (bus.in_valid && bus.in_ready) issued++;
         cyc++;
      end
      set_idle();
      tests++;
      if (got != 4) begin
         fails++;
         $display("FAIL bp_timeout: got %0d results, required 4", got);
      end
      repeat (4) begin
         @(negedge clk);
         tests++;
         if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_extra: out_valid=%b y=%h, required out_valid=0", bus.out_valid, bus.y);
         end
      end
   endtask

   task automatic test_reset_midstream();
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222;
      @(posedge clk); #1;
      bus.a = 16'h3333; bus.b = 16'h4444;
      @(posedge clk); #1;
      set_idle();
      @(posedge clk); #1;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.y !== 16'h3333) begin
         fails++;
         $display("FAIL rst_mid_pre: ov=%b y=%h, required ov=1 y=3333", bus.out_valid, bus.y);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (bus.out_valid !== 1'b0 || bus.y !== 16'h0000) begin
         fails++;
         $display("FAIL rst_mid_async: ov=%b y=%h, required ov=0 y=0000", bus.out_valid, bus.y);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      tests++;
      if (bus.in_ready !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid_ready_early: got %b, required 0", bus.in_ready);
      end
      @(posedge clk); #1;
      tests++;
      if (bus.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL rst_mid_ready: got %b, required 1", bus.in_ready);
      end
      repeat (5) begin
         @(negedge clk);
         tests++;
         if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_stale: out_valid=%b y=%h, required 0", bus.out_valid, bus.y);
         end
      end
   endtask

   task automatic test_random();
      logic [18:0] q[$];
      logic [18:0] e;
      logic [18:0] held = '0;
      logic        held_v = 1'b0;
      int          n;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         bus.in_valid  = $urandom_range(0, 3) != 0;
         bus.a = pick(); bus.b = pick();
         bus.ci = 1'($urandom); bus.sub = 1'($urandom); bus.sat = 1'($urandom);
         bus.out_ready = $urandom_range(0, 3) != 0;
         @(negedge clk);
         tests++;
         if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
            fails++;
            $display("FAIL rnd_in_ready %0d: got %b, required %b", i, bus.in_ready,
                     !bus.out_valid || bus.out_ready);
         end
         if (held_v) begin
            tests++;
            if (bus.out_valid !== 1'b1 || {bus.y, bus.c, bus.v, bus.z} !== held) begin
               fails++;
               $display("FAIL rnd_hold %0d: ov=%b yCVZ=%h, required ov=1 yCVZ=%h", i,
                        bus.out_valid, {bus.y, bus.c, bus.v, bus.z}, held);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL rnd_unexpected %0d: yCVZ=%h, required no output", i,
                        {bus.y, bus.c, bus.v, bus.z});
            end else begin
               e = q.pop_front();
               if ({bus.y, bus.c, bus.v, bus.z} !== e) begin
                  fails++;
                  $display("FAIL rnd_result %0d: yCVZ=%h, required %h", i,
                           {bus.y, bus.c, bus.v, bus.z}, e);
               end
            end
         end
         held_v = bus.out_valid && !bus.out_ready;
         held   = {bus.y, bus.c, bus.v, bus.z};
         if (bus.in_valid && bus.in_ready)
            q.push_back(model(bus.a, bus.b, bus.ci, bus.sub, bus.sat));
      end
      n = 0;
      while (q.size() != 0 && n < 20) begin
         @(posedge clk); #1;
         set_idle();
         bus.out_ready = 1'b1;
         @(negedge clk);
         if (bus.out_valid) begin
            e = q.pop_front();
            tests++;
            if ({bus.y, bus.c, bus.v, bus.z} !== e) begin
               fails++;
               $display("FAIL rnd_drain: yCVZ=%h, required %h", {bus.y, bus.c, bus.v, bus.z}, e);
            end
         end
         n++;
      end
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL rnd_drain_timeout: %0d results outstanding, required 0", q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_vectors();
      test_backpressure();
      test_reset_midstream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined signed/unsigned adder-subtractor for the heart-rate datapath. Used for sample differencing, baseline subtraction and interval accumulation.
- Successor to the 8-bit combinational adder. Adds:
  - configurable width;
  - carry chain split across pipeline stages;
  - subtract mode;
  - optional signed saturation;
  - zero flag;
  - valid/ready flow control.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be >= 2 and divisible by STAGES.
- STAGES, 2, number of pipeline stages. Each stage resolves WIDTH/STAGES bits of the carry chain. Allowed range is 1..WIDTH.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- IN_VALID  in  1  input transaction present
- IN_READY  out  1  block accepts input this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- CI  in  1  carry-in
- SUB  in  1  0 = add, 1 = subtract (B inverted)
- SAT  in  1  1 = clamp signed overflow
- OUT_VALID  out  1  result present
- OUT_READY  in  1  downstream accepts result
- Y  out  WIDTH  result
- C  out  1  carry-out of MSB (unsigned carry / not-borrow)
- V  out  1  signed overflow
- Z  out  1  Y == 0, evaluated after saturation

Behaviour:
- Reset: one clock; RST_N is asynchronous and active-low. While RST_N=0, all stage registers clear:
  - OUT_VALID=0, Y=0, C=0, V=0, Z=0;
  - IN_READY=0 while RST_N=0, and 1 from the first clock after release.
- Effective operand: Beff = SUB ? ~B : B.
  - Raw sum = A + Beff + CI, computed modulo 2^WIDTH.
  - True subtraction uses SUB=1, CI=1, giving A-B. With SUB=1, CI=0 the result is A-B-1.
- Flags:
  - C = carry out of bit WIDTH-1 of the raw sum.
  - V = (A[msb]==Beff[msb]) && (raw[msb]!=A[msb]). V is computed on the raw sum, before saturation.
- Saturation: if SAT=1 and V=1, Y = A[msb] ? {1,0..0} (most negative) : {0,1..1} (most positive). Otherwise Y = raw sum.
  - C and V report raw values even when Y is clamped.
- Pipeline structure:
  - Stage k (0-based) adds segment bits [(k+1)*SEG-1 : k*SEG], where SEG = WIDTH/STAGES, using the carry registered from stage k-1. Stage 0 uses CI.
  - Untouched upper operand bits, SUB, SAT and completed lower sum bits travel alongside in registers.
  - Flags and saturation are applied in the final stage's combinational path and registered at the output together with Y.
- Latency: a transaction accepted on edge n appears with OUT_VALID=1 after edge n+STAGES, provided no stall occurs.
- Throughput: one transaction per cycle when OUT_READY=1.
- Flow control: the whole pipeline uses a single global advance, adv = !OUT_VALID || OUT_READY.
  - IN_READY = adv.
  - When adv=1, every stage shifts one position. Valid bits shift too, so bubbles propagate and are not collapsed.
  - When adv=0, all stages, including Y, C, V and Z, hold.
  - Input transfer occurs when IN_VALID && IN_READY. If IN_VALID=0 on an advance, a bubble (valid=0) enters.
- Simultaneous accept and drain: in the same cycle, the output register loads the next stage's contents and stage 0 loads the new input.
- Output stability: while OUT_VALID=1 && OUT_READY=0, Y, C, V and Z must not change.
- Per-transaction modes: SUB and SAT are sampled with A and B. A mode change between back-to-back transactions affects only the later one.
- Reset mid-operation: all in-flight transactions are discarded and none emerge after release.
- STAGES=1: a single registered adder with latency 1.

Test Plan (WIDTH=16, STAGES=2, OUT_READY=1 unless stated):
- Add with cross-segment carry: A=0x00FF, B=0x0001, CI=0, SUB=0 -> 2 cycles later Y=0x0100, C=0, V=0, Z=0.
- Wrap: A=0xFFFF, B=0x0001, CI=0 -> Y=0x0000, C=1, V=0, Z=1.
- Positive overflow: A=0x7FFF, B=0x0001:
  - SAT=0 -> Y=0x8000, V=1, C=0;
  - SAT=1 -> Y=0x7FFF, V=1.
- Subtract: A=0x0005, B=0x0007, SUB=1, CI=1 -> Y=0xFFFE, C=0, V=0.
- Negative saturation: A=0x8000, B=0x0001, SUB=1, CI=1, SAT=1 -> Y=0x8000, V=1, C=1.
  - Same with SAT=0 -> Y=0x7FFF.
- Backpressure: issue 4 back-to-back adds (i+0x10, i for i=0..3) and hold OUT_READY=0 from cycle 3 to cycle 8.
  - IN_READY=0 once the output register holds a result.
  - Y holds 0x0010 steady throughout the stall.
  - After release, results 0x0010, 0x0012, 0x0014, 0x0016 appear in order: no loss, no duplication.
- Reset mid-stream: assert RST_N=0 asynchronously with 2 transactions in flight.
  - OUT_VALID=0 immediately, with no clock edge required.
  - After release, no stale result appears and IN_READY=1 on the next edge.
